// File: rtl/tvp_stream_gen.sv
// TVP-style raster timing and test-pattern generator.
// Raster counters plus IDLE/RUN/DRAIN control; every output is registered one cycle behind the counters.
module tvp_stream_gen #(
  parameter int H_ACTIVE = 512,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 48,
  parameter int H_TOTAL  = 640,
  parameter int V_ACTIVE = 384,
  parameter int V_FRONT  = 4,
  parameter int V_SYNC   = 4,
  parameter int V_TOTAL  = 400
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [2:0] PATTERN,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic [9:0] VIDEO,
  output logic       VISIBLE,
  output logic       FRAME_START,
  output logic [7:0] FRAME_CNT,
  output logic       BUSY
);

  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 5) ? $clog2(V_TOTAL) : 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [2:0]    pat;
  logic [7:0]    fcnt;

  logic       h_last, v_last, f_last, f_first, running, active, hs_n, vs_n;
  logic [2:0] pat_eff;
  logic [9:0] pix;

  always_comb begin
    h_last  = (hc == HW'(H_TOTAL - 1));
    v_last  = (vc == VW'(V_TOTAL - 1));
    f_last  = h_last && v_last;
    f_first = (hc == '0) && (vc == '0);
    running = (state != IDLE);
    active  = (hc < HW'(H_ACTIVE)) && (vc < VW'(V_ACTIVE));
    hs_n    = !((hc >= HW'(H_ACTIVE + H_FRONT)) && (hc < HW'(H_ACTIVE + H_FRONT + H_SYNC)));
    vs_n    = !((vc >= VW'(V_ACTIVE + V_FRONT)) && (vc < VW'(V_ACTIVE + V_FRONT + V_SYNC)));
    // The first pixel of a frame already uses the pattern being latched at that pixel.
    pat_eff = f_first ? PATTERN : pat;
    pix     = '0;
    case (pat_eff)
      3'd1:    pix = '1;
      3'd2:    pix = hc[9:0];
      3'd3:    pix = hc[3] ? '1 : '0;
      3'd4:    pix = (hc[4] ^ vc[4]) ? '1 : '0;
      3'd5:    pix = (hc[8:3] == fcnt[5:0]) ? '1 : '0;
      default: pix = '0;
    endcase
    if (!active) pix = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      hc          <= '0;
      vc          <= '0;
      pat         <= '0;
      fcnt        <= '0;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      VIDEO       <= '0;
      VISIBLE     <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= '0;
      BUSY        <= 1'b0;
    end else begin
      BUSY      <= running;
      FRAME_CNT <= fcnt;
      if (running) begin
        HSYNC       <= hs_n;
        VSYNC       <= vs_n;
        VIDEO       <= pix;
        VISIBLE     <= active;
        FRAME_START <= f_first;
        hc          <= h_last ? '0 : hc + 1'b1;
        if (h_last) vc <= v_last ? '0 : vc + 1'b1;
        if (f_first) pat <= PATTERN;
        if (f_last) fcnt <= fcnt + 1'b1;
        // Dropping ENABLE on the very last pixel ends the frame right there.
        if (ENABLE)      state <= RUN;
        else if (f_last) state <= IDLE;
        else             state <= DRAIN;
      end else begin
        HSYNC       <= 1'b1;
        VSYNC       <= 1'b1;
        VIDEO       <= '0;
        VISIBLE     <= 1'b0;
        FRAME_START <= 1'b0;
        hc          <= '0;
        vc          <= '0;
        if (ENABLE) state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_tvp_stream_gen.sv
// Randomized bench for tvp_stream_gen on a shrunken raster, checked cycle by cycle
// against a frame-position model of the raster.
module tb_tvp_stream_gen;

  localparam int HA = 20, HF = 1, HS = 2, HT = 24;
  localparam int VA = 5,  VF = 1, VS = 1, VT = 8;
  localparam int FRAME = HT * VT;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENABLE = 1'b0;
  logic [2:0] PATTERN = 3'd0;
  logic       HSYNC, VSYNC, VISIBLE, FRAME_START, BUSY;
  logic [9:0] VIDEO;
  logic [7:0] FRAME_CNT;

  tvp_stream_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .PATTERN(PATTERN),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .VIDEO(VIDEO), .VISIBLE(VISIBLE),
    .FRAME_START(FRAME_START), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // {HSYNC, VSYNC, VISIBLE, FRAME_START, BUSY, FRAME_CNT, VIDEO}
  logic [22:0] obs;
  assign obs = {HSYNC, VSYNC, VISIBLE, FRAME_START, BUSY, FRAME_CNT, VIDEO};

  task automatic check_eq(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [22:0] idle_vec(input int fc);
    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'(fc), 10'd0};
  endfunction

  function automatic logic [9:0] pixel(input int h, input int v, input int p, input int fc);
    if (h >= HA || v >= VA) return 10'd0;
    case (p)
      1: return 10'h3FF;
      2: return 10'(h % 1024);
      3: return ((h / 8) % 2 == 1) ? 10'h3FF : 10'd0;
      4: return (((h / 16) + (v / 16)) % 2 == 1) ? 10'h3FF : 10'd0;
      5: return (((h / 8) % 64) == (fc % 64)) ? 10'h3FF : 10'd0;
      default: return 10'd0;
    endcase
  endfunction

  // Model: a running flag, a linear pixel position within the frame, completed frames, latched pattern.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  int          m_fc  = 0;
  int          m_pat = 0;
  logic [22:0] exp_vec = {1'b1, 1'b1, 21'd0};

  always @(posedge CLK or negedge RESET_N) begin
    int h, v, pe;
    if (!RESET_N) begin
      m_run = 1'b0; m_pos = 0; m_fc = 0; m_pat = 0;
      exp_vec = idle_vec(0);
    end else if (m_run) begin
      h  = m_pos % HT;
      v  = m_pos / HT;
      pe = (m_pos == 0) ? int'(PATTERN) : m_pat;
      exp_vec = {!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
                 (h < HA && v < VA), (m_pos == 0), 1'b1, 8'(m_fc), pixel(h, v, pe, m_fc)};
      if (m_pos == 0) m_pat = int'(PATTERN);
      if (m_pos == FRAME - 1) m_fc = (m_fc + 1) % 256;
      m_run = ENABLE || (m_pos != FRAME - 1);
      m_pos = (m_pos + 1) % FRAME;
    end else begin
      exp_vec = idle_vec(m_fc);
      m_pos = 0;
      if (ENABLE) m_run = 1'b1;
    end
  end

  always @(negedge CLK) if (chk_en) check_eq("cycle", obs, exp_vec);

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    step(3);
    check_eq("reset_state", obs, idle_vec(0));
    RESET_N = 1'b1;
    chk_en  = 1'b1;
    step(4);

    // Ramp pattern: first frame start one cycle after the first RUN cycle.
    ENABLE = 1'b1; PATTERN = 3'd2;
    step(2);
    check_eq("first_fs", obs, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 10'd0});
    step(FRAME * 2);

    // Pattern change mid-frame, then a full stop and restart.
    step(FRAME / 2);
    PATTERN = 3'd4;
    step(FRAME);
    PATTERN = 3'd3;
    ENABLE = 1'b0;
    step(FRAME + 40);
    ENABLE = 1'b1;
    step(FRAME / 3);

    // Drop and restore ENABLE during drain.
    ENABLE = 1'b0;
    step(17);
    ENABLE = 1'b1;
    step(FRAME * 2);

    // Random ENABLE / PATTERN activity.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 2) ENABLE = ~ENABLE;
      if ($urandom_range(0, 99) < 3) PATTERN = 3'($urandom_range(0, 7));
      step(1);
    end

    // Asynchronous reset in the middle of a frame.
    ENABLE = 1'b1;
    step(FRAME + FRAME / 2);
    @(posedge CLK); #2;
    RESET_N = 1'b0;
    #1;
    check_eq("rst_async", obs, idle_vec(0));
    step(3);
    RESET_N = 1'b1;
    ENABLE = 1'b0;
    step(5);
    check_eq("post_rst_idle", obs, idle_vec(0));

    // Long run for the FRAME_CNT wrap with the moving bar pattern.
    ENABLE = 1'b1; PATTERN = 3'd5;
    for (int f = 0; f < 258; f++) begin
      if ($urandom_range(0, 9) == 0) PATTERN = 3'($urandom_range(0, 7));
      else PATTERN = 3'd5;
      step(FRAME);
    end
    ENABLE = 1'b0;
    step(FRAME + 10);
    check_eq("final_idle", obs, idle_vec(m_fc));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
